// File: rtl/cell_fetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lisp: heap tag encodings shared by the fetch unit and its consumers.
// ---------------------------------------------------------------------------
package lisp;
    localparam logic [7:0] NIL            = 8'h00;
    localparam logic [7:0] TYPE_NUMBER    = 8'h01;
    localparam logic [7:0] TYPE_CONS      = 8'h02;
    localparam logic [7:0] TYPE_FUNC_PRIM = 8'h03;
    localparam logic [7:0] TYPE_PRIM_CONS = 8'h04;
endpackage

// ---------------------------------------------------------------------------
// cell_fetch
// Reads one heap cell from a ROM with a registered (1-cycle latency) read
// port: the tag word first, then only the field words the tag needs, and
// presents the assembled cell on a valid/ready interface.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/req_ready request handshake; req_ready is high only when idle
//   req_ptr             address of the cell's tag word (sampled at accept)
//   rom_addr            registered ROM address
//   rom_data            ROM word for the address presented one cycle earlier
//   cell_valid/ready    output handshake
//   cell_ptr            pointer the cell was fetched from
//   cell_tag            tag word
//   cell_f0..cell_f2    fields at ptr+1..ptr+3 (NIL when unused)
//   cell_err            tag not recognised
// ---------------------------------------------------------------------------
module cell_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_ptr,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  cell_valid,
    input  logic                  cell_ready,
    output logic [ADDR_WIDTH-1:0] cell_ptr,
    output logic [DATA_WIDTH-1:0] cell_tag,
    output logic [DATA_WIDTH-1:0] cell_f0,
    output logic [DATA_WIDTH-1:0] cell_f1,
    output logic [DATA_WIDTH-1:0] cell_f2,
    output logic                  cell_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    localparam logic [DATA_WIDTH-1:0] NIL_W = DATA_WIDTH'(lisp::NIL);

    state_t     state, state_nxt;
    logic       accept;
    logic       done;
    // Edges seen in FETCH; the word captured at an edge is index phase-1.
    logic [2:0] phase;
    // Field count of the current cell, valid once the tag has been captured.
    logic [1:0] nfields;
    logic [1:0] nfields_c;
    logic       tag_known_c;

    // Decode the tag arriving on rom_data. Unknown tags need no fields.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path leaves it unassigned and infers a latch.
        nfields_c   = 2'd0;
        tag_known_c = 1'b1;
        case (rom_data)
            NIL_W:                            nfields_c = 2'd0;
            DATA_WIDTH'(lisp::TYPE_NUMBER):   nfields_c = 2'd1;
            DATA_WIDTH'(lisp::TYPE_CONS):     nfields_c = 2'd2;
            DATA_WIDTH'(lisp::TYPE_FUNC_PRIM): nfields_c = 2'd3;
            default:                          tag_known_c = 1'b0;
        endcase
    end

    // Next state. Completion happens on the edge that captures the last
    // required word: the tag itself when no fields are needed.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (phase == 3'd1)
                    done = (nfields_c == 2'd0);
                else if (phase >= 3'd2)
                    done = (phase == {1'b0, nfields} + 3'd1);
                if (done)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (cell_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign req_ready  = (state == IDLE);
    assign cell_valid = (state == HOLD);

    // Datapath. Reads run ahead of the captures, so words past the cell's
    // last field may be requested; they are simply never captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            cell_ptr <= '0;
            cell_tag <= NIL_W;
            cell_f0  <= NIL_W;
            cell_f1  <= NIL_W;
            cell_f2  <= NIL_W;
            cell_err <= 1'b0;
            phase    <= 3'd0;
            nfields  <= 2'd0;
        end else if (accept) begin
            rom_addr <= req_ptr;
            cell_ptr <= req_ptr;
            cell_tag <= NIL_W;
            cell_f0  <= NIL_W;
            cell_f1  <= NIL_W;
            cell_f2  <= NIL_W;
            cell_err <= 1'b0;
            phase    <= 3'd0;
            nfields  <= 2'd0;
        end else if (state == FETCH) begin
            rom_addr <= rom_addr + ADDR_WIDTH'(1);
            phase    <= phase + 3'd1;
            case (phase)
                3'd1: begin
                    cell_tag <= rom_data;
                    nfields  <= nfields_c;
                    cell_err <= ~tag_known_c;
                end
                3'd2:    cell_f0 <= rom_data;
                3'd3:    cell_f1 <= rom_data;
                3'd4:    cell_f2 <= rom_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_fetch.sv
`timescale 1ns/1ps
module tb_cell_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_ptr;
    logic [7:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic       cell_valid;
    logic       cell_ready;
    logic [7:0] cell_ptr, cell_tag, cell_f0, cell_f1, cell_f2;
    logic       cell_err;

    int checks = 0;
    int errors = 0;

    cell_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_ptr(req_ptr),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .cell_valid(cell_valid), .cell_ready(cell_ready),
        .cell_ptr(cell_ptr), .cell_tag(cell_tag),
        .cell_f0(cell_f0), .cell_f1(cell_f1), .cell_f2(cell_f2),
        .cell_err(cell_err)
    );

    always #5 clk = ~clk;

    // Heap ROM with a registered read port. Unlisted words hold 0xA5 so a
    // wrongly captured speculative word is visible.
    logic [7:0] rom [256];
    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'hA5;
        rom[8'h00] = lisp::NIL;
        rom[8'h01] = lisp::TYPE_NUMBER;    rom[8'h02] = 8'h12;
        rom[8'h05] = lisp::TYPE_FUNC_PRIM; rom[8'h06] = lisp::TYPE_PRIM_CONS;
        rom[8'h07] = lisp::NIL;            rom[8'h08] = lisp::NIL;
        rom[8'h09] = lisp::TYPE_CONS;      rom[8'h0A] = 8'h02;
        rom[8'h0B] = lisp::NIL;
        rom[8'h20] = 8'hEE;
        rom[8'hFE] = lisp::TYPE_CONS;      rom[8'hFF] = 8'h0C;
    end
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef enum {M_IDLE, M_BUSY, M_HOLD} mphase_t;
    mphase_t    mph   = M_IDLE;
    logic [7:0] e_ptr = 8'h00, e_addr = 8'h00, e_tag = 8'h00;
    logic [7:0] e_f0  = 8'h00, e_f1 = 8'h00, e_f2 = 8'h00;
    logic       e_err = 1'b0;
    int         e_lat = 0, age = 0;

    function automatic int field_count(input logic [7:0] tag);
        if (tag == lisp::NIL)            return 0;
        if (tag == lisp::TYPE_NUMBER)    return 1;
        if (tag == lisp::TYPE_CONS)      return 2;
        if (tag == lisp::TYPE_FUNC_PRIM) return 3;
        return -1;
    endfunction

    // A cell is known at accept time from the ROM contents; only its
    // arrival time (n+2 cycles, 2 for an unknown tag) has to be tracked.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mph = M_IDLE; e_ptr = 8'h00; e_addr = 8'h00; e_tag = 8'h00;
            e_f0 = 8'h00; e_f1 = 8'h00; e_f2 = 8'h00; e_err = 1'b0;
        end else begin
            case (mph)
                M_IDLE: if (req_valid) begin
                    int n;
                    n      = field_count(rom[req_ptr]);
                    e_ptr  = req_ptr;
                    e_addr = req_ptr;
                    e_tag  = rom[req_ptr];
                    e_err  = (n < 0);
                    e_f0   = (n >= 1) ? rom[8'(req_ptr + 8'd1)] : lisp::NIL;
                    e_f1   = (n >= 2) ? rom[8'(req_ptr + 8'd2)] : lisp::NIL;
                    e_f2   = (n >= 3) ? rom[8'(req_ptr + 8'd3)] : lisp::NIL;
                    e_lat  = (n < 0) ? 2 : n + 2;
                    age    = 0;
                    mph    = M_BUSY;
                end
                M_BUSY: begin
                    e_addr = e_addr + 8'd1;
                    age++;
                    if (age == e_lat) mph = M_HOLD;
                end
                M_HOLD: if (cell_ready) mph = M_IDLE;
                default: mph = M_IDLE;
            endcase
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        check("req_ready", req_ready, mph == M_IDLE);
        check("cell_valid", cell_valid, mph == M_HOLD);
        check("rom_addr", rom_addr, e_addr);
        check("cell_ptr", cell_ptr, e_ptr);
        if (mph != M_BUSY) begin
            check("cell_tag", cell_tag, e_tag);
            check("cell_f0", cell_f0, e_f0);
            check("cell_f1", cell_f1, e_f1);
            check("cell_f2", cell_f2, e_f2);
            check("cell_err", cell_err, e_err);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic fetch(input logic [7:0] ptr, output int lat,
                         output logic [7:0] a0, output logic [7:0] a1, output logic [7:0] a2);
        @(negedge clk);
        req_valid = 1'b1;
        req_ptr   = ptr;
        @(posedge clk);
        lat = -1;
        a0 = 8'hXX; a1 = 8'hXX; a2 = 8'hXX;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin a0 = rom_addr; req_valid = 1'b0; end
            if (i == 1) a1 = rom_addr;
            if (i == 2) a2 = rom_addr;
            if (cell_valid) begin lat = i; break; end
            check("busy_req_ready", req_ready, 1'b0);
        end
        if (lat < 0) check("fetch_timeout", 1'b0, 1'b1);
    endtask

    task automatic end_cell();
        @(negedge clk);
        check("post_hs_req_ready", req_ready, 1'b1);
        check("post_hs_valid", cell_valid, 1'b0);
    endtask

    task automatic check_cell(input string tag_name, input logic [7:0] p, input logic [7:0] t,
                              input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2,
                              input logic err);
        check({tag_name, "_ptr"}, cell_ptr, p);
        check({tag_name, "_tag"}, cell_tag, t);
        check({tag_name, "_f0"}, cell_f0, f0);
        check({tag_name, "_f1"}, cell_f1, f1);
        check({tag_name, "_f2"}, cell_f2, f2);
        check({tag_name, "_err"}, cell_err, err);
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_valid", cell_valid, 1'b0);
        check("rst_rom_addr", rom_addr, 8'h00);
        check_cell("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] a0, a1, a2;
        logic [7:0] s_tag, s_f0, s_f1, s_ptr;

        rst = 1'b1; req_valid = 1'b0; req_ptr = 8'h00; cell_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // NUMBER
        fetch(8'h01, lat, a0, a1, a2);
        check("num_latency", lat, 3);
        check_cell("num", 8'h01, 8'h01, 8'h12, 8'h00, 8'h00, 1'b0);
        end_cell();

        // CONS then FUNC_PRIM
        fetch(8'h09, lat, a0, a1, a2);
        check("cons_latency", lat, 4);
        check_cell("cons", 8'h09, 8'h02, 8'h02, 8'h00, 8'h00, 1'b0);
        end_cell();
        fetch(8'h05, lat, a0, a1, a2);
        check("prim_latency", lat, 5);
        check_cell("prim", 8'h05, 8'h03, 8'h04, 8'h00, 8'h00, 1'b0);
        end_cell();

        // NIL and unknown tag
        fetch(8'h00, lat, a0, a1, a2);
        check("nil_latency", lat, 2);
        check_cell("nil", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        end_cell();
        fetch(8'h20, lat, a0, a1, a2);
        check("unk_latency", lat, 2);
        check_cell("unk", 8'h20, 8'hEE, 8'h00, 8'h00, 8'h00, 1'b1);
        end_cell();

        // Address wrap
        fetch(8'hFE, lat, a0, a1, a2);
        check("wrap_a0", a0, 8'hFE);
        check("wrap_a1", a1, 8'hFF);
        check("wrap_a2", a2, 8'h00);
        check("wrap_latency", lat, 4);
        check_cell("wrap", 8'hFE, 8'h02, 8'h0C, 8'h00, 8'h00, 1'b0);
        end_cell();

        // Backpressure with request noise while holding
        cell_ready = 1'b0;
        fetch(8'h09, lat, a0, a1, a2);
        check("bp_latency", lat, 4);
        s_tag = cell_tag; s_f0 = cell_f0; s_f1 = cell_f1; s_ptr = cell_ptr;
        for (int i = 0; i < 10; i++) begin
            req_valid = i[0];
            req_ptr   = 8'(i * 7 + 1);
            @(negedge clk);
            check("bp_valid", cell_valid, 1'b1);
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_tag", cell_tag, s_tag);
            check("bp_f0", cell_f0, s_f0);
            check("bp_f1", cell_f1, s_f1);
            check("bp_ptr", cell_ptr, s_ptr);
        end
        cell_ready = 1'b1;
        req_valid  = 1'b1;
        req_ptr    = 8'h01;
        end_cell();
        check("bp_no_accept_ptr", cell_ptr, 8'h09);
        req_valid = 1'b0;

        // Reset one cycle into a FUNC_PRIM fetch
        @(negedge clk);
        req_valid = 1'b1; req_ptr = 8'h05;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", cell_valid, 1'b0);
        end

        fetch(8'h01, lat, a0, a1, a2);
        check("rst_num_latency", lat, 3);
        check_cell("rst_num", 8'h01, 8'h01, 8'h12, 8'h00, 8'h00, 1'b0);
        end_cell();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
